bus_arbiter: RTL and testbench

Three-port arbiter that shares the single SoC peripheral/memory bus between the CPU instruction port (A), the CPU data port (B) and the DMA engine (C). It sits between the CPU/DMA masters and the address decoder that fans the bus out to ROM, RAM, LED, UART, DMA, Timer and PLIC. It also bounds every transfer with a timeout, so an access to an unmapped address cannot hang the system.

---
 rtl/bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the SoC bus between CPU instruction (A), CPU data (B) and DMA (C) ports,
// bounding each transfer with a timeout. Define BUS_ARBITER_ROUND_ROBIN_EN for round-robin arbitration.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_pa_request,
  output logic        o_pa_ready,
  input  logic [31:0] i_pa_address,
  output logic [31:0] o_pa_rdata,
  input  logic        i_pb_rw,
  input  logic        i_pb_request,
  output logic        o_pb_ready,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic [31:0] o_pb_rdata,
  input  logic        i_pc_rw,
  input  logic        i_pc_request,
  output logic        o_pc_ready,
  input  logic [31:0] i_pc_address,
  input  logic [31:0] i_pc_wdata,
  output logic [31:0] o_pc_rdata,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0] COUNT_LAST = 16'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [2:0]       pick;
  logic [2:0]       grant, grant_next;
  logic [15:0]      count, count_next;
  logic             bus_request, bus_request_next;
  logic             bus_rw, bus_rw_next;
  logic [31:0]      bus_address, bus_address_next;
  logic [31:0]      bus_wdata, bus_wdata_next;
  logic [2:0]       ready, ready_next;
  logic [2:0][31:0] rdata, rdata_next;
  logic             timeout, timeout_next;
  logic             finish;
  logic [31:0]      finish_data;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
  // One-hot record of the last winner; reset value makes port A the first candidate.
  logic [2:0] last_grant;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_grant <= 3'b100;
    end else if (state == IDLE && pick != 3'b000) begin
      last_grant <= pick;
    end
  end

  always_comb begin
    pick = 3'b000;
    if (last_grant[0]) begin
      pick = i_pb_request ? 3'b010 : i_pc_request ? 3'b100 : i_pa_request ? 3'b001 : 3'b000;
    end else if (last_grant[1]) begin
      pick = i_pc_request ? 3'b100 : i_pa_request ? 3'b001 : i_pb_request ? 3'b010 : 3'b000;
    end else begin
      pick = i_pa_request ? 3'b001 : i_pb_request ? 3'b010 : i_pc_request ? 3'b100 : 3'b000;
    end
  end
`else
  always_comb begin
    pick = i_pc_request ? 3'b100 : i_pb_request ? 3'b010 : i_pa_request ? 3'b001 : 3'b000;
  end
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      grant       <= 3'b000;
      count       <= 16'd0;
      bus_request <= 1'b0;
      bus_rw      <= 1'b0;
      bus_address <= 32'd0;
      bus_wdata   <= 32'd0;
      ready       <= 3'b000;
      rdata       <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_next;
      grant       <= grant_next;
      count       <= count_next;
      bus_request <= bus_request_next;
      bus_rw      <= bus_rw_next;
      bus_address <= bus_address_next;
      bus_wdata   <= bus_wdata_next;
      ready       <= ready_next;
      rdata       <= rdata_next;
      timeout     <= timeout_next;
    end
  end

  // A device ready on the expiry cycle wins over the timeout, so real data is kept.
  always_comb begin
    state_next       = state;
    grant_next       = grant;
    count_next       = count;
    bus_request_next = bus_request;
    bus_rw_next      = bus_rw;
    bus_address_next = bus_address;
    bus_wdata_next   = bus_wdata;
    ready_next       = 3'b000;
    rdata_next       = rdata;
    timeout_next     = 1'b0;
    finish           = 1'b0;
    finish_data      = 32'd0;

    unique case (state)
      IDLE: begin
        if (pick != 3'b000) begin
          state_next       = BUSY;
          grant_next       = pick;
          count_next       = 16'd0;
          bus_request_next = 1'b1;
          bus_rw_next      = (pick[1] & i_pb_rw) | (pick[2] & i_pc_rw);
          bus_address_next = pick[2] ? i_pc_address : pick[1] ? i_pb_address : i_pa_address;
          bus_wdata_next   = pick[2] ? i_pc_wdata : pick[1] ? i_pb_wdata : 32'd0;
        end
      end
      BUSY: begin
        count_next = 16'(count + 16'd1);
        if (i_bus_ready) begin
          finish      = 1'b1;
          finish_data = i_bus_rdata;
        end else if (count == COUNT_LAST) begin
          finish       = 1'b1;
          timeout_next = 1'b1;
        end
        if (finish) begin
          state_next       = DONE;
          bus_request_next = 1'b0;
          ready_next       = grant;
          for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
              rdata_next[i] = finish_data;
            end
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_bus_request = bus_request;
  assign o_bus_rw      = bus_rw;
  assign o_bus_address = bus_address;
  assign o_bus_wdata   = bus_wdata;
  assign o_pa_ready    = ready[0];
  assign o_pb_ready    = ready[1];
  assign o_pc_ready    = ready[2];
  assign o_pa_rdata    = rdata[0];
  assign o_pb_rdata    = rdata[1];
  assign o_pc_rdata    = rdata[2];
  assign o_timeout     = timeout;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized transfers on bus_arbiter, checked against a
// transaction-level model of grant order, read data and completion latency.
module tb_bus_arbiter;

  localparam int TMO = 8;

  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic        i_pa_request, o_pa_ready;
  logic [31:0] i_pa_address, o_pa_rdata;
  logic        i_pb_rw, i_pb_request, o_pb_ready;
  logic [31:0] i_pb_address, i_pb_wdata, o_pb_rdata;
  logic        i_pc_rw, i_pc_request, o_pc_ready;
  logic [31:0] i_pc_address, i_pc_wdata, o_pc_rdata;
  logic        o_bus_rw, o_bus_request;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;
  logic        o_timeout;

  int          total = 0;
  int          bad = 0;
  logic [31:0] pay_addr[3];
  logic [31:0] pay_wdata[3];
  logic        pay_rw[3];
  logic [31:0] exp_rdata[3];
  logic [2:0]  pending;
  int          model_last;
  int          served[$];
  int          dev_latency;
  bit          dev_hang;
  int          dev_cnt;

  bus_arbiter #(.TIMEOUT(TMO)) dut (
    .i_clock(i_clock), .i_reset_n(i_reset_n),
    .i_pa_request(i_pa_request), .o_pa_ready(o_pa_ready),
    .i_pa_address(i_pa_address), .o_pa_rdata(o_pa_rdata),
    .i_pb_rw(i_pb_rw), .i_pb_request(i_pb_request), .o_pb_ready(o_pb_ready),
    .i_pb_address(i_pb_address), .i_pb_wdata(i_pb_wdata), .o_pb_rdata(o_pb_rdata),
    .i_pc_rw(i_pc_rw), .i_pc_request(i_pc_request), .o_pc_ready(o_pc_ready),
    .i_pc_address(i_pc_address), .i_pc_wdata(i_pc_wdata), .o_pc_rdata(o_pc_rdata),
    .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request),
    .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata),
    .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .o_timeout(o_timeout)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [31:0] dev_data(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h1234_5678;
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // Reference arbitration: first pending port in search order.
  function automatic int model_pick(input logic [2:0] pend, input int last);
    int idx;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    for (int k = 1; k <= 3; k++) begin
      idx = (last + k) % 3;
      if (pend[idx]) return idx;
    end
`else
    for (int k = 2; k >= 0; k--) begin
      idx = k;
      if (pend[idx]) return idx;
    end
`endif
    return 0;
  endfunction

  function automatic logic [31:0] port_rdata(input int p);
    if (p == 0) return o_pa_rdata;
    if (p == 1) return o_pb_rdata;
    return o_pc_rdata;
  endfunction

  // Downstream device: answers after dev_latency busy cycles unless hung.
  initial begin
    i_bus_ready = 1'b0;
    i_bus_rdata = 32'd0;
    dev_cnt = 0;
    forever begin
      @(negedge i_clock);
      i_bus_ready = 1'b0;
      i_bus_rdata = $urandom;
      if (o_bus_request) begin
        dev_cnt++;
        if (!dev_hang && dev_cnt == dev_latency) begin
          i_bus_ready = 1'b1;
          i_bus_rdata = dev_data(o_bus_address);
        end
      end else begin
        dev_cnt = 0;
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_requests(input logic [2:0] m);
    i_pa_request = m[0];
    i_pa_address = pay_addr[0];
    i_pb_request = m[1];
    i_pb_rw      = pay_rw[1];
    i_pb_address = pay_addr[1];
    i_pb_wdata   = pay_wdata[1];
    i_pc_request = m[2];
    i_pc_rw      = pay_rw[2];
    i_pc_address = pay_addr[2];
    i_pc_wdata   = pay_wdata[2];
  endtask

  task automatic set_payload(input int p, input logic rw, input logic [31:0] a, input logic [31:0] wd);
    pay_rw[p]    = (p == 0) ? 1'b0 : rw;
    pay_addr[p]  = a;
    pay_wdata[p] = wd;
  endtask

  task automatic apply_stimulus(input logic [2:0] m);
    @(negedge i_clock);
    pending = m;
    drive_requests(m);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_bus_req"}, o_bus_request, 0);
    check_output({tag, "_bus_rw"}, o_bus_rw, 0);
    check_output({tag, "_bus_addr"}, o_bus_address, 0);
    check_output({tag, "_bus_wdata"}, o_bus_wdata, 0);
    check_output({tag, "_ready"}, {29'd0, o_pc_ready, o_pb_ready, o_pa_ready}, 0);
    check_output({tag, "_timeout"}, o_timeout, 0);
    for (int p = 0; p < 3; p++) check_output($sformatf("%s_rdata%0d", tag, p), port_rdata(p), 0);
  endtask

  // Serves every pending port; exp_lat (if nonzero) is the negedge count to the first ready.
  task automatic serve_all(input int exp_lat);
    int w;
    int waited;
    bit first;
    logic [2:0] rdy;
    first = 1'b1;
    while (pending != 3'b000) begin
      w = model_pick(pending, model_last);
      waited = 0;
      rdy = 3'b000;
      while (rdy == 3'b000 && waited < 64) begin
        @(negedge i_clock);
        waited++;
        rdy = {o_pc_ready, o_pb_ready, o_pa_ready};
        if (o_bus_request && rdy == 3'b000) begin
          check_output("bus_addr", o_bus_address, pay_addr[w]);
          check_output("bus_rw", o_bus_rw, (w == 0) ? 1'b0 : pay_rw[w]);
          check_output("bus_wdata", o_bus_wdata, (w == 0) ? 32'd0 : pay_wdata[w]);
        end
      end
      check_output("ready_port", {29'd0, rdy}, 32'(3'b001 << w));
      if (rdy == 3'b000) begin
        pending = 3'b000;
        drive_requests(3'b000);
        break;
      end
      if (first && exp_lat > 0) check_output("latency", waited, exp_lat);
      first = 1'b0;
      exp_rdata[w] = dev_hang ? 32'd0 : dev_data(pay_addr[w]);
      for (int p = 0; p < 3; p++) check_output($sformatf("rdata%0d", p), port_rdata(p), exp_rdata[p]);
      check_output("timeout_flag", o_timeout, dev_hang);
      check_output("bus_req_low", o_bus_request, 0);
      model_last = w;
      served.push_back(w);
      pending[w] = 1'b0;
      drive_requests(pending);
      @(negedge i_clock);
      check_output("ready_one_cycle", {29'd0, o_pc_ready, o_pb_ready, o_pa_ready}, 0);
      check_output("timeout_one_cycle", o_timeout, 0);
      check_output("bus_gap", o_bus_request, 0);
    end
  endtask

  initial begin
    int order;
    i_reset_n = 1'b0;
    dev_latency = 2;
    dev_hang = 1'b0;
    model_last = 2;
    for (int p = 0; p < 3; p++) begin
      set_payload(p, 1'b0, 32'd0, 32'd0);
      exp_rdata[p] = 32'd0;
    end
    pending = 3'b000;
    drive_requests(3'b000);
    #12;
    check_all_zero("reset");
    @(negedge i_clock);
    i_reset_n = 1'b1;

    // Three-way contention straight out of reset.
    for (int p = 0; p < 3; p++) set_payload(p, 1'($urandom), $urandom, $urandom);
    served.delete();
    apply_stimulus(3'b111);
    serve_all(0);
    check_output("grant_count", served.size(), 3);
    if (served.size() == 3) begin
      order = served[0] * 16 + served[1] * 4 + served[2];
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
      check_output("grant_order", order, 6);
`else
      check_output("grant_order", order, 36);
`endif
    end

    $display("[TB] single read on port A");
    set_payload(0, 1'b0, 32'h0000_0010, 32'd0);
    dev_latency = 2;
    apply_stimulus(3'b001);
    serve_all(3);
    check_output("pa_rdata_const", o_pa_rdata, 32'h1234_5678);

    $display("[TB] write on port B");
    set_payload(1, 1'b1, 32'h1000_0004, 32'hDEAD_BEEF);
    dev_latency = 1;
    apply_stimulus(3'b010);
    serve_all(2);

    $display("[TB] unmapped address timeout");
    set_payload(1, 1'b0, 32'h7000_0000, 32'd0);
    dev_hang = 1'b1;
    apply_stimulus(3'b010);
    serve_all(TMO + 1);
    dev_hang = 1'b0;
    set_payload(0, 1'b0, $urandom, 32'd0);
    dev_latency = 3;
    apply_stimulus(3'b001);
    serve_all(4);

    $display("[TB] ready at and just before expiry");
    set_payload(2, 1'b0, $urandom, $urandom);
    dev_latency = TMO;
    apply_stimulus(3'b100);
    serve_all(TMO + 1);
    set_payload(1, 1'b1, $urandom, $urandom);
    dev_latency = TMO - 1;
    apply_stimulus(3'b010);
    serve_all(TMO);

    $display("[TB] random contention");
    for (int n = 0; n < 16; n++) begin
      for (int p = 0; p < 3; p++) set_payload(p, 1'($urandom), $urandom, $urandom);
      dev_latency = $urandom_range(1, 5);
      apply_stimulus(3'($urandom_range(1, 7)));
      serve_all(0);
    end

    $display("[TB] reset during a transfer");
    set_payload(1, 1'b0, $urandom, $urandom);
    dev_hang = 1'b1;
    apply_stimulus(3'b010);
    repeat (3) @(negedge i_clock);
    check_output("busy_before_reset", o_bus_request, 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    for (int p = 0; p < 3; p++) exp_rdata[p] = 32'd0;
    model_last = 2;
    repeat (2) begin
      @(negedge i_clock);
      check_output("ready_in_reset", {29'd0, o_pc_ready, o_pb_ready, o_pa_ready}, 0);
    end
    i_reset_n = 1'b1;
    dev_hang = 1'b0;
    dev_latency = 2;
    serve_all(3);

    for (int n = 0; n < 2; n++) begin
      for (int p = 0; p < 3; p++) set_payload(p, 1'($urandom), $urandom, $urandom);
      dev_latency = $urandom_range(1, 4);
      apply_stimulus(3'b111);
      serve_all(0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
